rgb_stream_unpacker: RTL

- Serial-to-parallel front end for the RGB-to-gray pipeline.
- Accepts one channel word per transfer on a valid/ready stream, ordered R, G, B, and assembles each triplet.
- Presents each triplet as three parallel words (Out0=R, Out1=G, Out2=B) with valid/ready, ready to feed the 3-channel pipeline register stage.
- Tracks frame alignment through a start-of-frame sideband and counts emitted pixels.

---
 rtl/rgb_stream_unpacker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rgb_stream_unpacker.sv
// Serial-to-parallel unpacker: gathers R, G, B channel words from a valid/ready
// stream into one parallel pixel, with SOF-based frame alignment and a pixel counter.
module rgb_stream_unpacker #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter bit REQUIRE_SOF = 1'b1
) (
    input  logic              CLK,
    input  logic              CLEAR,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    input  logic              In_Sof,
    output logic              In_Ready,
    output logic [DATA_W-1:0] Out0,
    output logic [DATA_W-1:0] Out1,
    output logic [DATA_W-1:0] Out2,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Resync_Err,
    output logic [CNT_W-1:0]  Pixel_Count
);

    typedef enum logic [1:0] {
        IDX_R = 2'd0,
        IDX_G = 2'd1,
        IDX_B = 2'd2
    } idx_t;

    idx_t              r_idx;
    idx_t              w_idx_next;
    logic [DATA_W-1:0] r_s0;
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_out0;
    logic [DATA_W-1:0] r_out1;
    logic [DATA_W-1:0] r_out2;
    logic              r_out_valid;
    logic              r_synced;
    logic              r_resync_err;
    logic [CNT_W-1:0]  r_pixel_count;

    logic w_in_ready;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_synced_ok;
    logic w_s0_we;
    logic w_s1_we;
    logic w_load;
    logic w_set_synced;
    logic w_set_err;

    // Only a B word that would overwrite an unconsumed pixel is refused; a SOF
    // word restarts the triplet and never touches the output register.
    assign w_in_ready  = ENABLE && !(r_idx == IDX_B && !In_Sof && r_out_valid && !Out_Ready);
    assign w_in_xfer   = In_Valid && w_in_ready;
    assign w_out_xfer  = r_out_valid && Out_Ready && ENABLE;
    assign w_synced_ok = !REQUIRE_SOF || r_synced;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_idx_next   = r_idx;
        w_s0_we      = 1'b0;
        w_s1_we      = 1'b0;
        w_load       = 1'b0;
        w_set_synced = 1'b0;
        w_set_err    = 1'b0;
        if (w_in_xfer) begin
            if (In_Sof) begin
                w_idx_next   = IDX_G;
                w_s0_we      = 1'b1;
                w_set_synced = 1'b1;
                w_set_err    = (r_idx != IDX_R);
            end else if (w_synced_ok) begin
                unique case (r_idx)
                    IDX_R: begin
                        w_s0_we    = 1'b1;
                        w_idx_next = IDX_G;
                    end
                    IDX_G: begin
                        w_s1_we    = 1'b1;
                        w_idx_next = IDX_B;
                    end
                    IDX_B: begin
                        w_load     = 1'b1;
                        w_idx_next = IDX_R;
                    end
                    default: w_idx_next = IDX_R;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLEAR) begin
            r_idx         <= IDX_R;
            r_s0          <= '0;
            r_s1          <= '0;
            r_out0        <= '0;
            r_out1        <= '0;
            r_out2        <= '0;
            r_out_valid   <= 1'b0;
            r_synced      <= 1'b0;
            r_resync_err  <= 1'b0;
            r_pixel_count <= '0;
        end else begin
            r_idx <= w_idx_next;
            if (w_s0_we)      r_s0         <= In_Data;
            if (w_s1_we)      r_s1         <= In_Data;
            if (w_set_synced) r_synced     <= 1'b1;
            if (w_set_err)    r_resync_err <= 1'b1;
            // A completing triplet reloads the output even while the old pixel leaves.
            if (w_load) begin
                r_out0      <= r_s0;
                r_out1      <= r_s1;
                r_out2      <= In_Data;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_xfer) r_pixel_count <= r_pixel_count + CNT_W'(1);
        end
    end

    assign In_Ready    = w_in_ready;
    assign Out0        = r_out0;
    assign Out1        = r_out1;
    assign Out2        = r_out2;
    assign Out_Valid   = r_out_valid;
    assign Resync_Err  = r_resync_err;
    assign Pixel_Count = r_pixel_count;

endmodule
